rally_referee: RTL
==================

Name: rally_referee

Overview:
- Parametrised rally and match controller for the pong display pipeline.
- Watches the ball's active signal at both goal lines and checks it against separate top and bottom paddle actives.
- Counts scores, runs the post-miss pause and declares a match winner.
- Drives the round reset that restarts the ball and paddles, and feeds the scoreboard instances.

Parameters:
- VRES, 720, active lines per frame
- PADDLE_H, 20, paddle height in lines; goal lines are PADDLE_H-1 (top) and VRES-PADDLE_H (bottom)
- SCORE_W, 4, score counter width
- WIN_SCORE, 9, points that end a match; must be ≤ 2^SCORE_W-1
- PAUSE_FRAMES, 2, frames held in pause after a miss; must be ≥1
- MATCH_HOLD_FRAMES, 120, frames match_over is held before scores clear; must be ≥1

Ports:
- pixel_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- fsync  in  1  one-cycle start-of-frame pulse
- vpos  in  12  signed current line
- active_obj  in  1  ball covers current pixel
- active_pad_top  in  1  top paddle covers current pixel
- active_pad_bot  in  1  bottom paddle covers current pixel
- score_top  out  SCORE_W  top player score
- score_bot  out  SCORE_W  bottom player score
- game_over  out  1  high during pause
- round_rst  out  1  reset for ball/paddles; high in PAUSE and MATCH_END
- point_pulse  out  1  one cycle when a point is awarded
- match_over  out  1  high in MATCH_END
- winner  out  1  0 = top won, 1 = bottom won; valid while match_over

Behaviour:
- Reset: while rst_n is low, all outputs are 0, state is ARM, and all counters and the miss-side register are 0. Reset asserts asynchronously and releases synchronously to pixel_clk. Reset mid-rally or mid-pause drops everything immediately.
- All outputs are registered; every transition takes effect on the next pixel_clk edge.
- ARM: on fsync go to PLAY. At most one goal-line evaluation is made per frame.
- PLAY, top goal line hit: vpos==PADDLE_H-1 and active_obj.
  - If active_pad_top is also high in the same cycle, it is a return: go to ARM.
  - Otherwise latch miss_side=TOP and go to PASSING.
- PLAY, bottom goal line: same rule at vpos==VRES-PADDLE_H, using active_pad_bot and miss_side=BOT.
- The wrong side's paddle never rescues a miss.
- PASSING: the first cycle with active_obj low goes to PAUSE, clears the pause counter and sets game_over.
- PAUSE: on each fsync the pause counter increments. On the fsync where it equals PAUSE_FRAMES-1:
  - Award the point. A top miss gives bottom +1; a bottom miss gives top +1.
  - Pulse point_pulse for one cycle and clear game_over.
  - If the scorer's new score ≥ WIN_SCORE: go to MATCH_END with winner = scorer.
  - Otherwise go to ARM.
- MATCH_END:
  - match_over=1 and round_rst=1; scores are frozen.
  - The fsync count reaching MATCH_HOLD_FRAMES-1 clears both scores and match_over, then goes to ARM.
- fsync arriving in the same cycle as a goal-line hit: the goal evaluation takes priority (fsync only matters in ARM, PAUSE and MATCH_END).
- Scores never wrap. An increment that would exceed 2^SCORE_W-1 saturates, which is unreachable under the default win rule.

Optional Feature:
- Macro: RALLY_WIN_BY_TWO_EN.
- Defined:
  - A match ends only when the scorer's score is ≥ WIN_SCORE and the scorer leads by ≥ 2.
  - If the scorer is at 2^SCORE_W-1 and not winning, both scores are set to WIN_SCORE-1 (deuce collapse), so there is no saturation deadlock.
- Undefined: the first player to reach WIN_SCORE wins; the deuce logic is absent.

Test Plan:
- Ball active at vpos=19 with active_pad_top=1 in the same cycle → state returns to ARM, scores unchanged, game_over stays 0.
- Ball active at vpos=19 with active_pad_top=0 and active_pad_bot=1 → PASSING, then game_over=1. On the 2nd subsequent fsync: score_bot 0→1, point_pulse is high for exactly 1 cycle, game_over returns to 0.
- Bottom miss at vpos=700 with score_top=8 → score_top becomes 9, match_over=1, winner=0, round_rst=1. After 120 fsyncs both scores return to 0 and match_over returns to 0.
- rst_n pulled low mid-PAUSE with score_bot=5 → all outputs 0 asynchronously. After release, the first fsync moves to PLAY.
- RALLY_WIN_BY_TWO_EN defined, scores 9–8, top scores → 10–8 ends the match with winner=0. From 9–9, the bottom scoring gives 9–10 with no match_over.
- RALLY_WIN_BY_TWO_EN defined, SCORE_W=4, scores 15–14 is unreachable; forcing 14–15 and the bottom scoring again → both scores set to 8 (deuce collapse), no match_over.

Source files
------------

// File: rtl/rally_referee_if.sv
// Signal bundle between the pong frame/object layers (master) and the rally referee (slave).
interface rally_referee_if #(
  parameter int unsigned SCORE_W = 4
);
  logic                fsync;
  logic signed [11:0]  vpos;
  logic                active_obj;
  logic                active_pad_top;
  logic                active_pad_bot;
  logic [SCORE_W-1:0]  score_top;
  logic [SCORE_W-1:0]  score_bot;
  logic                game_over;
  logic                round_rst;
  logic                point_pulse;
  logic                match_over;
  logic                winner;

  modport master (
    output fsync, vpos, active_obj, active_pad_top, active_pad_bot,
    input  score_top, score_bot, game_over, round_rst, point_pulse, match_over, winner
  );

  modport slave (
    input  fsync, vpos, active_obj, active_pad_top, active_pad_bot,
    output score_top, score_bot, game_over, round_rst, point_pulse, match_over, winner
  );
endinterface

// File: rtl/rally_referee.sv
// Rally and match referee: goal-line miss detection, scoring, post-miss pause and match hold.
// Optional macro RALLY_WIN_BY_TWO_EN: win needs a two-point lead, with deuce collapse at saturation.
module rally_referee #(
  parameter int unsigned VRES              = 720,
  parameter int unsigned PADDLE_H          = 20,
  parameter int unsigned SCORE_W           = 4,
  parameter int unsigned WIN_SCORE         = 9,
  parameter int unsigned PAUSE_FRAMES      = 2,
  parameter int unsigned MATCH_HOLD_FRAMES = 120
) (
  input  logic           pixel_clk,
  input  logic           rst_n,
  rally_referee_if.slave bus
);

  localparam int unsigned VPOS_W  = 12;
  localparam int unsigned CNT_MAX = (PAUSE_FRAMES > MATCH_HOLD_FRAMES) ? PAUSE_FRAMES
                                                                       : MATCH_HOLD_FRAMES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [VPOS_W-1:0]  TOP_LINE   = VPOS_W'(PADDLE_H - 1);
  localparam logic [VPOS_W-1:0]  BOT_LINE   = VPOS_W'(VRES - PADDLE_H);
  localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(MATCH_HOLD_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
`ifdef RALLY_WIN_BY_TWO_EN
  localparam logic [SCORE_W-1:0] DEUCE_S    = SCORE_W'(WIN_SCORE - 1);
`endif

  typedef enum logic [2:0] {
    ST_ARM,
    ST_PLAY,
    ST_PASSING,
    ST_PAUSE,
    ST_MATCH_END
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_top_q, score_top_d;
  logic [SCORE_W-1:0] score_bot_q, score_bot_d;
  logic               miss_bot_q, miss_bot_d;
  logic               winner_q, winner_d;
  logic               point_q, point_d;
  logic               game_over_q, game_over_d;
  logic               round_rst_q, round_rst_d;
  logic               match_over_q, match_over_d;
  logic [1:0]         rst_sync_q;
  logic               rst_int_n;

  logic               top_hit, bot_hit;
  logic [SCORE_W-1:0] scorer_old, scorer_new;
  logic               win;
`ifdef RALLY_WIN_BY_TWO_EN
  logic [SCORE_W-1:0] other_score;
  logic               deuce;
`endif

  // Reset asserts immediately, releases two pixel_clk edges later.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign top_hit = bus.active_obj && (bus.vpos == TOP_LINE);
  assign bot_hit = bus.active_obj && (bus.vpos == BOT_LINE);

  // Prospective award for the pending miss; miss_bot_q=1 means the top player scores.
  always_comb begin
    scorer_old = miss_bot_q ? score_top_q : score_bot_q;
    scorer_new = (scorer_old == SCORE_MAX) ? SCORE_MAX : scorer_old + SCORE_W'(1);
`ifdef RALLY_WIN_BY_TWO_EN
    other_score = miss_bot_q ? score_bot_q : score_top_q;
    win   = (scorer_new >= WIN_S) &&
            ({1'b0, scorer_new} >= ({1'b0, other_score} + (SCORE_W+1)'(2)));
    deuce = !win && (scorer_new == SCORE_MAX);
`else
    win   = (scorer_new >= WIN_S);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_top_d = score_top_q;
    score_bot_d = score_bot_q;
    miss_bot_d  = miss_bot_q;
    winner_d    = winner_q;
    point_d     = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (bus.fsync) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (top_hit) begin
          if (bus.active_pad_top) begin
            state_d = ST_ARM;
          end else begin
            miss_bot_d = 1'b0;
            state_d    = ST_PASSING;
          end
        end else if (bot_hit) begin
          if (bus.active_pad_bot) begin
            state_d = ST_ARM;
          end else begin
            miss_bot_d = 1'b1;
            state_d    = ST_PASSING;
          end
        end
      end
      ST_PASSING: begin
        if (!bus.active_obj) begin
          cnt_d   = '0;
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (bus.fsync) begin
          if (cnt_q == PAUSE_LAST) begin
            point_d = 1'b1;
            cnt_d   = '0;
            if (miss_bot_q) score_top_d = scorer_new;
            else            score_bot_d = scorer_new;
`ifdef RALLY_WIN_BY_TWO_EN
            if (deuce) begin
              score_top_d = DEUCE_S;
              score_bot_d = DEUCE_S;
            end
`endif
            if (win) begin
              winner_d = ~miss_bot_q;
              state_d  = ST_MATCH_END;
            end else begin
              state_d  = ST_ARM;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_MATCH_END: begin
        if (bus.fsync) begin
          if (cnt_q == HOLD_LAST) begin
            score_top_d = '0;
            score_bot_d = '0;
            cnt_d       = '0;
            state_d     = ST_ARM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_ARM;
    endcase

    // Status outputs follow the state being entered so they line up with the registered state.
    game_over_d  = (state_d == ST_PAUSE);
    round_rst_d  = (state_d == ST_PAUSE) || (state_d == ST_MATCH_END);
    match_over_d = (state_d == ST_MATCH_END);
  end

  always_ff @(posedge pixel_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= ST_ARM;
      cnt_q        <= '0;
      score_top_q  <= '0;
      score_bot_q  <= '0;
      miss_bot_q   <= 1'b0;
      winner_q     <= 1'b0;
      point_q      <= 1'b0;
      game_over_q  <= 1'b0;
      round_rst_q  <= 1'b0;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_top_q  <= score_top_d;
      score_bot_q  <= score_bot_d;
      miss_bot_q   <= miss_bot_d;
      winner_q     <= winner_d;
      point_q      <= point_d;
      game_over_q  <= game_over_d;
      round_rst_q  <= round_rst_d;
      match_over_q <= match_over_d;
    end
  end

  assign bus.score_top   = score_top_q;
  assign bus.score_bot   = score_bot_q;
  assign bus.game_over   = game_over_q;
  assign bus.round_rst   = round_rst_q;
  assign bus.point_pulse = point_q;
  assign bus.match_over  = match_over_q;
  assign bus.winner      = winner_q;

endmodule
